buff_uart_host: RTL and testbench
=================================

# buff_uart_host

Bus-side sequencer for `buff_uart`: accepts one data word per valid/ready handshake, loads it into the UART at `tx_address`, waits one full serial frame, then fetches one word from `rx_address` and presents it on an output valid/ready stream. It sits between a streaming producer/consumer and the `buff_uart_if` bus signals, driving the address/strobe side of that interface. It is built for the loopback and echo-peer case, where every transmitted word yields exactly one received word.

## Interface
Parameters:
- `width`, 8, data word width; must equal `buff_uart_if.width`
- `address_width`, 8, width of `active_address`
- `clock_freq`, 1_000_000, clock frequency in Hz
- `baud_rate`, 100_000, serial bit rate
- `rx_address`, 'd3, UART receive-data address
- `tx_address`, 'd4, UART transmit-data address
- `guard_cycles`, 4, extra cycles added to each frame wait to cover UART start latency

Ports:
- `clock`  in  1  sole clock, rising edge
- `resetn`  in  1  reset, synchronous, active-low
- `in_data`  in  width  word to transmit
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  host can accept a word
- `out_data`  out  width  received word
- `out_valid`  out  1  `out_data` valid
- `out_ready`  in  1  consumer accepts `out_data`
- `bus_active_address`  out  address_width  drives `active_address`
- `bus_read_enable`  out  1  drives `read_enable` (1-cycle pulse = load TX word)
- `bus_write_enable`  out  1  drives `write_enable` (1-cycle pulse = fetch RX word)
- `bus_data_in`  out  width  drives `data_in`
- `bus_data_out`  in  width  from `data_out`

## Operation
- Derived constants: `ticks_per_bit = clock_freq / baud_rate` (integer division); `frame_cycles = ticks_per_bit*(width+2) + guard_cycles`. 1 start bit, `width` data bits LSB first, 1 stop bit.
- FSM states: QUIET, IDLE, LOAD, WAIT_FRAME, FETCH, CAPTURE, OUTPUT.
- QUIET: entered on reset; counts `frame_cycles` cycles so that a frame interrupted by reset drains; then IDLE.
- IDLE: `in_ready`=1. When `in_valid && in_ready` at an edge, latch `in_data` and go to LOAD.
- LOAD (1 cycle): `bus_active_address`=`tx_address`, `bus_read_enable`=1, `bus_data_in`=latched word; then WAIT_FRAME.
- WAIT_FRAME: exactly `frame_cycles` cycles; then FETCH.
- FETCH (1 cycle): `bus_active_address`=`rx_address`, `bus_write_enable`=1; then CAPTURE.
- CAPTURE (1 cycle): `bus_data_out` is sampled into `out_data` at the end of this cycle; then OUTPUT.
- OUTPUT: `out_valid`=1, `out_data` stable until `out_valid && out_ready` at an edge; then IDLE.
- `bus_read_enable` and `bus_write_enable` are never high together. Outside LOAD/FETCH, both are 0 and `bus_active_address`=0.
- `bus_data_in` holds the last loaded word between loads.

## Timing
- All outputs are registered.
- Reset values: `in_ready`=0, `out_valid`=0, `out_data`=0, `bus_active_address`=0, `bus_read_enable`=0, `bus_write_enable`=0, `bus_data_in`=0.
- After `resetn` rises, `in_ready` goes high `frame_cycles`+1 edges later.
- Accept edge = cycle 0: LOAD in cycle 1, WAIT_FRAME in cycles 2..frame_cycles+1, FETCH in cycle frame_cycles+2, CAPTURE in cycle frame_cycles+3, `out_valid` high from cycle frame_cycles+4.
- `in_ready` drops on the edge after acceptance. Only one word is in flight; there is no buffering.
- If `out_ready` is already high when `out_valid` rises, OUTPUT lasts 1 cycle and `in_ready` rises the next cycle. Back-to-back throughput is therefore one word per frame_cycles+6 cycles.
- `out_ready` stalls of any length are legal. No word is lost or duplicated.
- `resetn` low in any state: at the next edge all outputs take their reset values, the latched word is discarded, and the FSM restarts in QUIET.

## Structure
- Package `buff_uart_host_pkg` contains:
  - the state enum `host_state_t`;
  - the function `frame_cycles(clock_freq, baud_rate, width, guard_cycles)`;
  - `frame_cycles` counter-width helper using `$clog2`.
- One sub-module, `cycle_timer`: loadable down-counter with `load`, `load_value`, and a `done` pulse. It is shared by QUIET and WAIT_FRAME.

## Test plan
All scenarios use the defaults (ticks_per_bit=10, frame_cycles=104) with `buff_uart` instantiated and `rx` tied to `tx`.
- Reset release → `in_ready`=0 for 104 edges, =1 at edge 105; all bus outputs 0 throughout.
- `in_data`=8'h0A accepted with `out_ready`=1 →
  - a single `bus_read_enable` pulse at `tx_address`=4 with `bus_data_in`=8'h0A;
  - serial `tx` shows start 0, bits LSB first, stop 1 at 10 cycles per bit;
  - `out_valid` rises 108 cycles after accept with `out_data`=8'h0A.
- Words 8'h3E then 8'hA5 back-to-back, `out_ready`=1 → outputs 8'h3E then 8'hA5, in order, 110 cycles apart.
- `out_ready`=0 for 50 cycles after `out_valid` → `out_data` stable, `in_ready`=0 throughout, no bus strobes; one transfer occurs when `out_ready` rises.
- `resetn` pulled low for 1 cycle mid-WAIT_FRAME → all outputs reset next edge, no `out_valid`, QUIET for 104 cycles; then a fresh word 8'h55 echoes correctly.
- Bus monitor across all tests → `bus_read_enable` && `bus_write_enable` never both 1; each strobe high exactly 1 cycle.

Source files
------------

// File: rtl/buff_uart_host_pkg.sv
// Shared types and frame-timing helpers for the buff_uart bus sequencer.
package buff_uart_host_pkg;

  // Sequencer states: drain after reset, wait for a word, strobe it into the
  // UART, sit out one serial frame, strobe the echo out, capture it, hand it on.
  typedef enum logic [2:0] {
    ST_QUIET      = 3'd0,
    ST_IDLE       = 3'd1,
    ST_LOAD       = 3'd2,
    ST_WAIT_FRAME = 3'd3,
    ST_FETCH      = 3'd4,
    ST_CAPTURE    = 3'd5,
    ST_OUTPUT     = 3'd6
  } host_state_t;

  // Cycles covering one start bit, width data bits, one stop bit, plus guard.
  function automatic int unsigned frame_cycles(
    input int unsigned clock_freq,
    input int unsigned baud_rate,
    input int unsigned width,
    input int unsigned guard_cycles
  );
    return (clock_freq / baud_rate) * (width + 32'd2) + guard_cycles;
  endfunction

  // Bits needed for a down-counter that must hold the value 'cycles'.
  function automatic int unsigned counter_width(input int unsigned cycles);
    if (cycles < 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(cycles + 32'd1);
    end
  endfunction

endpackage

// File: rtl/buff_uart_host_if.sv
// Stream-in, stream-out and UART bus signals of the sequencer, bundled.
interface buff_uart_host_if
  import buff_uart_host_pkg::*;
#(
  parameter int unsigned width         = 8,
  parameter int unsigned address_width = 8
);
  logic [width-1:0]         in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic [width-1:0]         out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [address_width-1:0] bus_active_address;
  logic                     bus_read_enable;
  logic                     bus_write_enable;
  logic [width-1:0]         bus_data_in;
  logic [width-1:0]         bus_data_out;

  // Sequencer side.
  modport master (
    input  in_data, in_valid, out_ready, bus_data_out,
    output in_ready, out_data, out_valid,
    output bus_active_address, bus_read_enable, bus_write_enable, bus_data_in
  );

  // Producer / consumer / UART side.
  modport slave (
    output in_data, in_valid, out_ready, bus_data_out,
    input  in_ready, out_data, out_valid,
    input  bus_active_address, bus_read_enable, bus_write_enable, bus_data_in
  );
endinterface

// File: rtl/buff_uart_host_cycle_timer.sv
// Loadable down-counter; o_done is high for exactly one cycle when an armed
// count reaches zero. Reset arms it with reset_value so the post-reset drain
// wait needs no extra load request.
module cycle_timer #(
  parameter int unsigned             cnt_width   = 8,
  parameter logic [cnt_width-1:0]    reset_value = '0
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 i_load,
  input  logic [cnt_width-1:0] i_load_value,
  output logic                 o_done
);
  logic [cnt_width-1:0] r_count;
  logic                 r_armed;
  logic                 w_done;

  assign w_done = r_armed && (r_count == '0);
  assign o_done = w_done;

  // Count down after a load; disarm once the zero has been reported.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_count <= reset_value;
      r_armed <= 1'b1;
    end else if (i_load) begin
      r_count <= i_load_value;
      r_armed <= 1'b1;
    end else if (w_done) begin
      r_armed <= 1'b0;
    end else if (r_count != '0) begin
      r_count <= r_count - cnt_width'(1);
    end
  end
endmodule

// File: rtl/buff_uart_host.sv
// Bus-side sequencer for buff_uart in loopback/echo use: one word in, one
// TX load strobe, one frame of waiting, one RX fetch strobe, one word out.
module buff_uart_host
  import buff_uart_host_pkg::*;
#(
  parameter int unsigned width         = 8,
  parameter int unsigned address_width = 8,
  parameter int unsigned clock_freq    = 1_000_000,
  parameter int unsigned baud_rate     = 100_000,
  parameter int unsigned rx_address    = 3,
  parameter int unsigned tx_address    = 4,
  parameter int unsigned guard_cycles  = 4
) (
  input  logic             clock,
  input  logic             resetn,
  buff_uart_host_if.master bus
);
  localparam int unsigned FRAME_CYCLES = frame_cycles(clock_freq, baud_rate, width, guard_cycles);
  localparam int unsigned CNT_WIDTH    = counter_width(FRAME_CYCLES);
  localparam logic [CNT_WIDTH-1:0]     FRAME_COUNT = CNT_WIDTH'(FRAME_CYCLES);
  localparam logic [address_width-1:0] TX_ADDR     = address_width'(tx_address);
  localparam logic [address_width-1:0] RX_ADDR     = address_width'(rx_address);
  localparam logic [address_width-1:0] NO_ADDR     = '0;

  localparam logic [2:0] S_QUIET      = 3'(ST_QUIET);
  localparam logic [2:0] S_IDLE       = 3'(ST_IDLE);
  localparam logic [2:0] S_LOAD       = 3'(ST_LOAD);
  localparam logic [2:0] S_WAIT_FRAME = 3'(ST_WAIT_FRAME);
  localparam logic [2:0] S_FETCH      = 3'(ST_FETCH);
  localparam logic [2:0] S_CAPTURE    = 3'(ST_CAPTURE);
  localparam logic [2:0] S_OUTPUT     = 3'(ST_OUTPUT);

  logic [2:0]               r_state;
  logic                     r_in_ready;
  logic                     r_out_valid;
  logic [width-1:0]         r_out_data;
  logic [address_width-1:0] r_address;
  logic                     r_read_enable;
  logic                     r_write_enable;
  logic [width-1:0]         r_data_in;

  logic [2:0]               w_next_state;
  logic                     w_accept;
  logic                     w_timer_done;

  // The timer is reloaded at the accept edge so its zero lands on the last
  // WAIT_FRAME cycle; reset reloads it for the QUIET drain.
  cycle_timer #(
    .cnt_width   (CNT_WIDTH),
    .reset_value (FRAME_COUNT)
  ) u_timer (
    .clock        (clock),
    .resetn       (resetn),
    .i_load       (w_accept),
    .i_load_value (FRAME_COUNT),
    .o_done       (w_timer_done)
  );

  // Next-state decode; also flags the input handshake.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_QUIET: begin
        if (w_timer_done) w_next_state = S_IDLE;
        else              w_next_state = S_QUIET;
      end
      S_IDLE: begin
        if (bus.in_valid && r_in_ready) begin
          w_accept     = 1'b1;
          w_next_state = S_LOAD;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_LOAD:       w_next_state = S_WAIT_FRAME;
      S_WAIT_FRAME: begin
        if (w_timer_done) w_next_state = S_FETCH;
        else              w_next_state = S_WAIT_FRAME;
      end
      S_FETCH:      w_next_state = S_CAPTURE;
      S_CAPTURE:    w_next_state = S_OUTPUT;
      S_OUTPUT: begin
        if (bus.out_ready && r_out_valid) w_next_state = S_IDLE;
        else                              w_next_state = S_OUTPUT;
      end
      default:      w_next_state = S_QUIET;
    endcase
  end

  // State and all outputs registered; outputs decoded from the next state so
  // they line up with the state they belong to.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state        <= S_QUIET;
      r_in_ready     <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_address      <= NO_ADDR;
      r_read_enable  <= 1'b0;
      r_write_enable <= 1'b0;
      r_data_in      <= '0;
    end else begin
      r_state        <= w_next_state;
      r_in_ready     <= (w_next_state == S_IDLE);
      r_out_valid    <= (w_next_state == S_OUTPUT);
      r_read_enable  <= (w_next_state == S_LOAD);
      r_write_enable <= (w_next_state == S_FETCH);
      if (w_next_state == S_LOAD) begin
        r_address <= TX_ADDR;
      end else if (w_next_state == S_FETCH) begin
        r_address <= RX_ADDR;
      end else begin
        r_address <= NO_ADDR;
      end
      // The accepted word goes straight to the bus data register and stays
      // there until the next load.
      if (w_accept) begin
        r_data_in <= bus.in_data;
      end
      // The UART has the received word on data_out during CAPTURE.
      if (r_state == S_CAPTURE) begin
        r_out_data <= bus.bus_data_out;
      end
    end
  end

  assign bus.in_ready           = r_in_ready;
  assign bus.out_valid          = r_out_valid;
  assign bus.out_data           = r_out_data;
  assign bus.bus_active_address = r_address;
  assign bus.bus_read_enable    = r_read_enable;
  assign bus.bus_write_enable   = r_write_enable;
  assign bus.bus_data_in        = r_data_in;
endmodule

// File: tb/tb_buff_uart_host.sv
// Directed + random bench for buff_uart_host. The UART is stood in for by an
// echo peer: the word loaded at the TX address comes back at the RX address.
module tb_buff_uart_host;
  localparam int FREQ  = 1_000_000;
  localparam int BAUD  = 100_000;
  localparam int W     = 8;
  localparam int GUARD = 4;
  localparam int TPB   = FREQ / BAUD;              // 10
  localparam int FRAME = TPB * (W + 2) + GUARD;    // 104
  localparam logic [7:0] TXA = 8'd4;
  localparam logic [7:0] RXA = 8'd3;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  buff_uart_host_if #(.width(W), .address_width(8)) u_if ();

  buff_uart_host #(
    .width(W), .address_width(8), .clock_freq(FREQ), .baud_rate(BAUD),
    .rx_address(3), .tx_address(4), .guard_cycles(GUARD)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (u_if)
  );

  int errors = 0;
  int checks = 0;
  int out_hs = 0;
  int words_done = 0;
  logic [7:0] exp_q[$];
  logic [7:0] peer_q[$];
  logic mon_en  = 1'b0;
  logic prev_re = 1'b0;
  logic prev_we = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Echo peer: remembers loaded words, returns the oldest on a fetch strobe,
  // and shows noise on data_out otherwise.
  always @(posedge clock) begin
    if (!resetn) begin
      peer_q.delete();
      u_if.bus_data_out <= 8'($urandom);
    end else begin
      if (u_if.bus_read_enable && u_if.bus_active_address == TXA)
        peer_q.push_back(u_if.bus_data_in);
      if (u_if.bus_write_enable && u_if.bus_active_address == RXA && peer_q.size() > 0)
        u_if.bus_data_out <= peer_q.pop_front();
      else
        u_if.bus_data_out <= 8'($urandom);
    end
  end

  // Output handshake counter.
  always @(posedge clock) begin
    if (resetn && u_if.out_valid === 1'b1 && u_if.out_ready === 1'b1) out_hs <= out_hs + 1;
  end

  // Bus monitor: strobes exclusive, one cycle wide, correct address, address 0 otherwise.
  always @(negedge clock) begin
    if (mon_en) begin
      check("strobe_excl", u_if.bus_read_enable && u_if.bus_write_enable, 0);
      check("re_width", prev_re && u_if.bus_read_enable, 0);
      check("we_width", prev_we && u_if.bus_write_enable, 0);
      if (u_if.bus_read_enable)       check("re_addr", u_if.bus_active_address, TXA);
      else if (u_if.bus_write_enable) check("we_addr", u_if.bus_active_address, RXA);
      else                            check("idle_addr", u_if.bus_active_address, 0);
    end
    prev_re <= u_if.bus_read_enable;
    prev_we <= u_if.bus_write_enable;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  u_if.in_ready, 0);
    check({tag, "_out_valid"}, u_if.out_valid, 0);
    check({tag, "_out_data"},  u_if.out_data, 0);
    check({tag, "_addr"},      u_if.bus_active_address, 0);
    check({tag, "_re"},        u_if.bus_read_enable, 0);
    check({tag, "_we"},        u_if.bus_write_enable, 0);
    check({tag, "_data_in"},   u_if.bus_data_in, 0);
  endtask

  // Called at the negedge where resetn has just been raised.
  task automatic quiet_window(input string tag);
    for (int k = 1; k <= FRAME + 1; k++) begin
      @(posedge clock); @(negedge clock);
      check({tag, "_in_ready"}, u_if.in_ready, (k >= FRAME + 1) ? 1 : 0);
      check({tag, "_no_valid"}, u_if.out_valid, 0);
      check({tag, "_no_strobe"}, u_if.bus_read_enable | u_if.bus_write_enable, 0);
    end
  endtask

  task automatic wait_in_ready();
    int n = 0;
    while (u_if.in_ready !== 1'b1 && n < 400) begin
      @(posedge clock); @(negedge clock); n++;
    end
    check("in_ready_wait", u_if.in_ready, 1);
  endtask

  // One full transaction; entered and left at a negedge.
  task automatic send_word(input logic [7:0] w, input int stall);
    int j;
    logic [7:0] exp;
    wait_in_ready();
    u_if.in_data  = w;
    u_if.in_valid = 1'b1;
    if (stall > 0) u_if.out_ready = 1'b0;
    @(posedge clock);                 // accept edge (cycle 0)
    exp_q.push_back(w);
    @(negedge clock);
    u_if.in_valid = 1'b0;
    u_if.in_data  = 8'($urandom);
    check("in_ready_drop", u_if.in_ready, 0);
    check("load_re", u_if.bus_read_enable, 1);
    check("load_addr", u_if.bus_active_address, TXA);
    check("load_data", u_if.bus_data_in, w);
    j = 0;
    while (u_if.out_valid !== 1'b1 && j < 300) begin
      @(posedge clock); @(negedge clock); j++;
    end
    check("out_valid_cycle", j + 1, FRAME + 4);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : ~w;
    check("out_data", u_if.out_data, exp);
    for (int s = 0; s < stall; s++) begin
      check("stall_valid", u_if.out_valid, 1);
      check("stall_data", u_if.out_data, exp);
      check("stall_in_ready", u_if.in_ready, 0);
      check("stall_strobe", u_if.bus_read_enable | u_if.bus_write_enable, 0);
      @(posedge clock); @(negedge clock);
    end
    u_if.out_ready = 1'b1;
    @(posedge clock);                 // output handshake edge
    @(negedge clock);
    words_done++;
    check("out_valid_drop", u_if.out_valid, 0);
    check("in_ready_back", u_if.in_ready, 1);
    check("data_in_hold", u_if.bus_data_in, w);
  endtask

  initial begin
    u_if.in_data   = 8'h00;
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b1;
    resetn = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    mon_en = 1'b1;
    check_reset_outputs("rst");
    resetn = 1'b1;
    quiet_window("quiet0");

    send_word(8'h0A, 0);
    send_word(8'h3E, 0);
    send_word(8'hA5, 0);
    send_word(8'($urandom), 50);
    for (int i = 0; i < 6; i++) send_word(8'($urandom), int'($urandom_range(0, 4)));

    // Reset in the middle of a frame wait.
    wait_in_ready();
    u_if.in_data  = 8'hC3;
    u_if.in_valid = 1'b1;
    @(posedge clock); @(negedge clock);
    u_if.in_valid = 1'b0;
    repeat (50) @(posedge clock);
    @(negedge clock);
    resetn = 1'b0;
    @(posedge clock); @(negedge clock);
    check_reset_outputs("midrst");
    exp_q.delete();
    resetn = 1'b1;
    quiet_window("quiet1");
    send_word(8'h55, 0);

    repeat (5) @(posedge clock);
    @(negedge clock);
    check("handshakes", out_hs, words_done);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
